mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_if.sv | 11 +
 rtl/mem_responder.sv | 84 ++++++++
 tb/tb_mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// mem_if: cache-to-memory request/response bus
interface mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory answering cache read/write requests
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        proc_reset,
  mem_if.slave        bus,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] op_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [0:(1<<ADDR_BITS)-1];
  logic req, err_nx, enter, is_wr;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] wd;
  assign req = bus.mem_read | bus.mem_write;
  assign enter = state_nx == RESP;
  // with LATENCY=1 the response is entered straight from IDLE, so use live inputs there
  assign is_wr = state == IDLE ? bus.mem_write : op_q[0];
  assign idx = state == IDLE ? bus.mem_addr[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
  assign wd = state == IDLE ? bus.mem_wdata : wdata_q;
  // next state, latency countdown and protocol-violation detection
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    err_nx = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = LATENCY == 1 ? RESP : WAIT;
        cnt_nx = 4'(LATENCY - 1);
        err_nx = bus.mem_read & bus.mem_write;
      end
      WAIT: if (!req) begin
        state_nx = IDLE;
        cnt_nx = '0;
        err_nx = 1'b1;
      end else begin
        state_nx = cnt == 4'd1 ? RESP : WAIT;
        cnt_nx = cnt - 4'd1;
        err_nx = {bus.mem_read, bus.mem_write} != op_q || bus.mem_addr != addr_q || bus.mem_wdata != wdata_q;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  // state, registered response, counters and request capture
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      rd_count <= '0;
      wr_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.mem_ready <= enter;
      bus.mem_rdata <= enter && !is_wr ? mem[idx] : '0;
      rd_count <= rd_count + {15'd0, enter && !is_wr};
      wr_count <= wr_count + {15'd0, enter && is_wr};
      proto_err <= proto_err | err_nx;
      if (state == IDLE) begin
        op_q <= {bus.mem_read, bus.mem_write};
        addr_q <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
    end
  end
  // storage is never cleared; a reset edge suppresses the pending write
  always_ff @(posedge clk) begin
    if (!proc_reset && enter && is_wr) mem[idx] <= wd;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;
  typedef struct {int cyc; logic [31:0] data; bit chk;} exp_t;
  logic clk = 0, proc_reset = 1, mon_on = 0;
  int cyc = 0, tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  logic [15:0] rc0, wc0, rc1, wc1;
  logic pe0, pe1;
  mem_if b0();
  mem_if b1();
  mem_responder #(.LATENCY(4), .ADDR_BITS(10)) dut (.clk(clk), .proc_reset(proc_reset), .bus(b0), .rd_count(rc0), .wr_count(wc0), .proto_err(pe0));
  mem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (.clk(clk), .proc_reset(proc_reset), .bus(b1), .rd_count(rc1), .wr_count(wc1), .proto_err(pe1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic pop_chk(input string name, input exp_t e, input logic [31:0] rdata);
    check({name, " ready cycle"}, cyc, e.cyc);
    if (e.chk) check({name, " rdata"}, rdata, e.data);
  endtask
  always @(negedge clk) if (mon_on) begin
    if (b0.mem_ready === 1'b1) begin
      if (q0.size() == 0) check("unexpected ready L4", 1, 0);
      else pop_chk("L4", q0.pop_front(), b0.mem_rdata);
    end else check("idle rdata L4", b0.mem_rdata, 0);
    if (b1.mem_ready === 1'b1) begin
      if (q1.size() == 0) check("unexpected ready L1", 1, 0);
      else pop_chk("L1", q1.pop_front(), b1.mem_rdata);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d, input logic [31:0] e, input bit chk);
    b0.mem_read = r;
    b0.mem_write = w;
    b0.mem_addr = a;
    b0.mem_wdata = d;
    q0.push_back('{cyc + 4, e, chk});
    repeat (5) step();
  endtask
  task automatic idle(input int n);
    b0.mem_read = 0;
    b0.mem_write = 0;
    repeat (n) step();
  endtask
  task automatic do_reset();
    idle(0);
    proc_reset = 1;
    step();
    proc_reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    {b0.mem_read, b0.mem_write, b0.mem_addr, b0.mem_wdata} = '0;
    {b1.mem_read, b1.mem_write, b1.mem_addr, b1.mem_wdata} = '0;
    repeat (3) step();
    proc_reset = 0;
    mon_on = 1;
    check("reset ready", b0.mem_ready, 0);
    check("reset rdata", b0.mem_rdata, 0);
    check("reset rd_count", rc0, 0);
    check("reset wr_count", wc0, 0);
    check("reset proto_err", pe0, 0);
    req(0, 1, 30'h005, 32'hDEADBEEF, 0, 0);
    idle(1);
    check("wr_count after write", wc0, 1);
    req(1, 0, 30'h005, 0, 32'hDEADBEEF, 1);
    idle(1);
    check("rd_count after read", rc0, 1);
    req(0, 1, 30'h003, 32'h11111111, 0, 0);
    req(1, 0, 30'h003, 0, 32'h11111111, 1);
    idle(1);
    check("b2b wr_count", wc0, 2);
    check("b2b rd_count", rc0, 2);
    req(0, 1, 30'h00000407, 32'hA5A5A5A5, 0, 0);
    req(1, 0, 30'h007, 0, 32'hA5A5A5A5, 1);
    idle(1);
    check("alias proto_err", pe0, 0);
    req(0, 1, 30'h010, 32'h0, 0, 0);
    idle(1);
    check("wr_count before reset", wc0, 4);
    b0.mem_write = 1;
    b0.mem_addr = 30'h010;
    b0.mem_wdata = 32'h12345678;
    repeat (2) step();
    do_reset();
    idle(6);
    check("reset-in-wait wr_count", wc0, 0);
    check("reset-in-wait rd_count", rc0, 0);
    check("reset-in-wait proto_err", pe0, 0);
    req(1, 0, 30'h010, 0, 32'h0, 1);
    idle(1);
    b0.mem_read = 1;
    b0.mem_addr = 30'h005;
    repeat (3) step();
    idle(6);
    check("drop rd_count", rc0, 1);
    check("drop proto_err", pe0, 1);
    req(1, 1, 30'h020, 32'hCAFEF00D, 0, 0);
    req(1, 0, 30'h020, 0, 32'hCAFEF00D, 1);
    idle(1);
    check("both-high wr_count", wc0, 1);
    check("both-high rd_count", rc0, 2);
    check("sticky proto_err", pe0, 1);
    do_reset();
    idle(1);
    check("proto_err cleared", pe0, 0);
    b0.mem_write = 1;
    b0.mem_addr = 30'h030;
    b0.mem_wdata = 32'h00000055;
    q0.push_back('{cyc + 4, 0, 0});
    step();
    b0.mem_addr = 30'h031;
    b0.mem_wdata = 32'h00000066;
    repeat (4) step();
    req(1, 0, 30'h030, 0, 32'h00000055, 1);
    idle(1);
    check("changed-input proto_err", pe0, 1);
    check("changed-input wr_count", wc0, 1);
    force dut.wr_count = 16'hFFFF;
    #1;
    release dut.wr_count;
    req(0, 1, 30'h040, 32'h1, 0, 0);
    idle(1);
    check("wr_count wrap", wc0, 0);
    b1.mem_write = 1;
    b1.mem_addr = 30'h001;
    b1.mem_wdata = 32'h00000077;
    q1.push_back('{cyc + 1, 0, 0});
    step();
    step();
    b1.mem_write = 0;
    b1.mem_read = 1;
    q1.push_back('{cyc + 1, 32'h00000077, 1});
    step();
    step();
    b1.mem_read = 0;
    idle(2);
    check("L1 wr_count", wc1, 1);
    check("L1 rd_count", rc1, 1);
    idle(8);
    check("L4 pending responses", q0.size(), 0);
    check("L1 pending responses", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
